alu_scan_display: RTL and testbench

//  Downstream display stage for the 4-bit ALU result (max 8-bit product, 225).

---
 rtl/alu_scan_display_pkg.sv | 66 ++++++
 rtl/alu_scan_display_if.sv | 9 +
 rtl/alu_scan_display_bin2bcd_serial.sv | 69 ++++++
 rtl/alu_scan_display.sv | 63 ++++++
 tb/tb_alu_scan_display.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_scan_display_pkg.sv
// rtl/alu_scan_display_pkg.sv - shared constants and helpers for the ALU result display
package alu_scan_display_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [1:0] IDX_UNITS    = 2'd0;
    localparam logic [1:0] IDX_TENS     = 2'd1;
    localparam logic [1:0] IDX_HUNDREDS = 2'd2;

    localparam logic [2:0] DE_UNITS    = 3'd0;
    localparam logic [2:0] DE_TENS     = 3'd1;
    localparam logic [2:0] DE_HUNDREDS = 3'd2;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_pattern = SEG_0;
            4'd1:    seg_pattern = SEG_1;
            4'd2:    seg_pattern = SEG_2;
            4'd3:    seg_pattern = SEG_3;
            4'd4:    seg_pattern = SEG_4;
            4'd5:    seg_pattern = SEG_5;
            4'd6:    seg_pattern = SEG_6;
            4'd7:    seg_pattern = SEG_7;
            4'd8:    seg_pattern = SEG_8;
            4'd9:    seg_pattern = SEG_9;
            default: seg_pattern = SEG_BLANK;
        endcase
    endfunction

    // Leading zeros blank; units always lit so a zero result still shows "0".
    function automatic logic [6:0] digit_seg(input logic [1:0] sel, input logic [3:0] hundreds,
                                             input logic [3:0] tens, input logic [3:0] units);
        case (sel)
            IDX_UNITS:    digit_seg = seg_pattern(units);
            IDX_TENS:     digit_seg = (hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_pattern(tens);
            IDX_HUNDREDS: digit_seg = (hundreds == 4'd0) ? SEG_BLANK : seg_pattern(hundreds);
            default:      digit_seg = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [2:0] de_code(input logic [1:0] sel);
        case (sel)
            IDX_TENS:     de_code = DE_TENS;
            IDX_HUNDREDS: de_code = DE_HUNDREDS;
            default:      de_code = DE_UNITS;
        endcase
    endfunction

endpackage

// File: rtl/alu_scan_display_if.sv
// rtl/alu_scan_display_if.sv - load/value/busy handshake between ALU and display stage
interface alu_scan_display_if;
    logic       load;
    logic [7:0] value;
    logic       busy;

    modport master (output load, output value, input busy);
    modport slave  (input load, input value, output busy);
endinterface

// File: rtl/alu_scan_display_bin2bcd_serial.sv
// rtl/alu_scan_display_bin2bcd_serial.sv - serial double-dabble 8-bit binary to 3-digit BCD
module bin2bcd_serial
    import alu_scan_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  value,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        done
);

    conv_state_t state, state_next;
    logic [7:0]  shift_q;
    logic [11:0] accum_q;
    logic [2:0]  iter_q;
    logic [11:0] accum_adj;
    logic [19:0] step;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        accum_adj = {add3(accum_q[11:8]), add3(accum_q[7:4]), add3(accum_q[3:0])};
        step      = {accum_adj, shift_q} << 1;
    end

    // bcd carries the post-step accumulator so the final digits are usable on the done edge.
    assign bcd  = step[19:8];
    assign busy = (state == CONV_RUN);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            CONV_IDLE: if (load) state_next = CONV_RUN;
            CONV_RUN: begin
                if (iter_q == 3'd7) begin
                    done       = 1'b1;
                    state_next = CONV_IDLE;
                end
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CONV_IDLE;
            shift_q <= 8'd0;
            accum_q <= 12'd0;
            iter_q  <= 3'd0;
        end else begin
            state <= state_next;
            if (state == CONV_IDLE && load) begin
                shift_q <= value;
                accum_q <= 12'd0;
                iter_q  <= 3'd0;
            end else if (state == CONV_RUN) begin
                shift_q <= step[7:0];
                accum_q <= step[19:8];
                iter_q  <= iter_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/alu_scan_display.sv
// rtl/alu_scan_display.sv - captures ALU result, converts to BCD, scans 3 digits on one 7-seg bus
module alu_scan_display
    import alu_scan_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                clk,
    input  logic                rst,
    alu_scan_display_if.slave   bus,
    output logic [6:0]          seg,
    output logic [2:0]          DE
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       idx, idx_next;
    logic             refresh_wrap;
    logic [11:0]      conv_bcd;
    logic             conv_done;
    logic [3:0]       hundreds, tens, units;

    bin2bcd_serial u_conv (
        .clk   (clk),
        .rst   (rst),
        .load  (bus.load),
        .value (bus.value),
        .busy  (bus.busy),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        refresh_wrap = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
        idx_next     = idx;
        if (refresh_wrap) idx_next = (idx == IDX_HUNDREDS) ? IDX_UNITS : idx + 2'd1;
    end

    // seg is rebuilt every edge from the held digits, so a commit shows up one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= IDX_UNITS;
            hundreds    <= 4'd0;
            tens        <= 4'd0;
            units       <= 4'd0;
            seg         <= SEG_0;
            DE          <= DE_UNITS;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            idx         <= idx_next;
            DE          <= de_code(idx_next);
            seg         <= digit_seg(idx_next, hundreds, tens, units);
            if (conv_done) begin
                hundreds <= conv_bcd[11:8];
                tens     <= conv_bcd[7:4];
                units    <= conv_bcd[3:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_scan_display.sv
// tb/tb_alu_scan_display.sv - scoreboard bench for alu_scan_display with REFRESH_DIV=4
module tb_alu_scan_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg;
    logic [2:0] DE;

    always #5 clk = ~clk;

    alu_scan_display_if bus ();

    alu_scan_display #(.REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .seg (seg),
        .DE  (DE)
    );

    int tests = 0;
    int fails = 0;
    int m_cnt = 0;
    int m_idx = 0;
    int m_busy_cnt = 0;
    int shown = 0;
    logic prev_busy = 1'b0;
    int sb[$];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg_for(input int v, input int sel);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        case (sel)
            0: return seg_of(u);
            1: return (h == 0 && t == 0) ? 7'b0000000 : seg_of(t);
            2: return (h == 0) ? 7'b0000000 : seg_of(h);
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock: advance the reference model with the inputs present at the edge, then compare.
    task automatic tick();
        logic       ld;
        logic       r;
        int         v;
        logic [6:0] es;
        ld = bus.load;
        r  = rst;
        v  = int'(bus.value);
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 0;
            m_idx = 0;
            m_busy_cnt = 0;
            sb.delete();
            shown = 0;
        end else begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 3;
            end else begin
                m_cnt++;
            end
            if (ld && m_busy_cnt == 0) begin
                m_busy_cnt = 8;
                sb.push_back(v);
            end else if (m_busy_cnt > 0) begin
                m_busy_cnt--;
            end
        end
        es = exp_seg_for(shown, m_idx);
        check("de", 32'(DE), 32'(m_idx));
        check("seg", 32'(seg), 32'(es));
        check("busy", 32'(bus.busy), 32'(m_busy_cnt != 0));
        if (!r && prev_busy && !bus.busy) begin
            check("commit_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) shown = sb.pop_front();
        end
        prev_busy = bus.busy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_load(input int v);
        bus.load  = 1'b1;
        bus.value = 8'(v);
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (bus.busy && guard < 20) begin
            tick();
            guard++;
        end
        check("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.value = 8'd0;

        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(13);

        pulse_load(225);
        wait_idle();
        run(13);

        pulse_load(7);
        wait_idle();
        run(13);
        pulse_load(105);
        wait_idle();
        run(13);

        pulse_load(225);
        tick();
        bus.load  = 1'b1;
        bus.value = 8'd9;
        tick();
        bus.load  = 1'b0;
        wait_idle();
        pulse_load(9);
        wait_idle();
        run(13);

        pulse_load(144);
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(24);

        pulse_load(225);
        wait_idle();
        run(13);
        pulse_load(0);
        wait_idle();
        run(13);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
